interboard_tx_scheduler: RTL and testbench

INTERBOARD_TX_SCHEDULER -- requirements
Module: interboard_tx_scheduler

---
 rtl/interboard_tx_scheduler.sv | 175 +++++++++++++++++
 tb/tb_interboard_tx_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interboard_tx_scheduler.sv
// Interboard transmit scheduler.
// Two requesters feed an in-order message queue through a round-robin arbiter. An FSM
// pops one message at a time and launches it to the communication block. The FSM then
// waits for the busy/idle handshake on inter_ready. If the handshake stalls, the message
// is relaunched up to MAX_RETRY times. After that it is dropped and tx_error is pulsed.
//
// Ports:
//   clk, rst (async active-low), interboard_rst (sync flush, active-high)
//   src{0,1}_valid/_msg_type/_number in, src{0,1}_ready out : requester handshakes
//   inter_ready in   : communication block idle (1) / busy (0)
//   transmit out     : one-cycle launch pulse
//   ctrl_en, ctrl_msg_type, ctrl_number out : message presented to the comm block
//   fifo_count out   : queued entries
//   tx_error out     : one-cycle pulse when a message is dropped
module interboard_tx_scheduler #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        interboard_rst,
    input  logic                        src0_valid,
    input  logic [2:0]                  src0_msg_type,
    input  logic [4:0]                  src0_number,
    output logic                        src0_ready,
    input  logic                        src1_valid,
    input  logic [2:0]                  src1_msg_type,
    input  logic [4:0]                  src1_number,
    output logic                        src1_ready,
    input  logic                        inter_ready,
    output logic                        transmit,
    output logic                        ctrl_en,
    output logic [2:0]                  ctrl_msg_type,
    output logic [4:0]                  ctrl_number,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx_error
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned TmoW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CntW-1:0]   CntFull  = CntW'(FIFO_DEPTH);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

    state_e            state_q;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              rr_q;
    logic [TmoW-1:0]   timeout_q;
    logic [RetryW-1:0] retry_q;

    logic       full, push, pop, take0;
    logic [7:0] push_data, head;

    // Readies are forced low during either reset so nothing is accepted that cycle.
    always_comb begin
        full       = (count_q == CntFull);
        src0_ready = rst && !interboard_rst && !full && (!src1_valid || !rr_q);
        src1_ready = rst && !interboard_rst && !full && (!src0_valid || rr_q);
        take0      = src0_valid && src0_ready;
        push       = take0 || (src1_valid && src1_ready);
        push_data  = take0 ? {src0_msg_type, src0_number} : {src1_msg_type, src1_number};
        head       = mem_q[rd_ptr_q];
        pop        = (state_q == StIdle) && (count_q != '0) && inter_ready && !interboard_rst;
    end

    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
        end else if (interboard_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            // Only a contested grant hands priority to the other source.
            if (push && src0_valid && src1_valid) begin
                rr_q <= !rr_q;
            end
        end
    end

    // transmit/ctrl_en/tx_error are registered alongside the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            retry_q       <= '0;
            timeout_q     <= '0;
            transmit      <= 1'b0;
            ctrl_en       <= 1'b0;
            ctrl_msg_type <= '0;
            ctrl_number   <= '0;
            tx_error      <= 1'b0;
        end else if (interboard_rst) begin
            state_q   <= StIdle;
            retry_q   <= '0;
            timeout_q <= '0;
            transmit  <= 1'b0;
            ctrl_en   <= 1'b0;
            tx_error  <= 1'b0;
        end else begin
            transmit <= 1'b0;
            tx_error <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        ctrl_msg_type <= head[7:5];
                        ctrl_number   <= head[4:0];
                        retry_q       <= '0;
                        timeout_q     <= '0;
                        transmit      <= 1'b1;
                        ctrl_en       <= 1'b1;
                        state_q       <= StLaunch;
                    end
                end
                StLaunch: begin
                    state_q <= StWaitBusy;
                end
                StWaitBusy, StWaitDone: begin
                    // Timeout wins over handshake progress so a late edge cannot leave
                    // the counter past its terminal value.
                    if (timeout_q == TmoLast) begin
                        timeout_q <= '0;
                        if (retry_q < RetryMax) begin
                            retry_q  <= retry_q + RetryW'(1);
                            transmit <= 1'b1;
                            state_q  <= StLaunch;
                        end else begin
                            tx_error <= 1'b1;
                            ctrl_en  <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end else begin
                        timeout_q <= timeout_q + TmoW'(1);
                        if (state_q == StWaitBusy && !inter_ready) begin
                            state_q <= StWaitDone;
                        end else if (state_q == StWaitDone && inter_ready) begin
                            ctrl_en <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// Testbench for interboard_tx_scheduler.
// An arbitration/full table is applied cycle by cycle. Hand-written sequences cover the
// single-message launch, ordering, timeout/retry, flush and async reset cases.
// A scoreboard receives every accepted message and checks each launch against it.
module tb_interboard_tx_scheduler;
    localparam int unsigned Depth = 4;
    localparam int unsigned Tmo   = 8;
    localparam int unsigned Retry = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       interboard_rst = 1'b0;
    logic       src0_valid = 1'b0, src1_valid = 1'b0;
    logic [2:0] src0_msg_type = '0, src1_msg_type = '0;
    logic [4:0] src0_number = '0, src1_number = '0;
    logic       src0_ready, src1_ready;
    logic       inter_ready = 1'b1;
    logic       transmit, ctrl_en, tx_error;
    logic [2:0] ctrl_msg_type;
    logic [4:0] ctrl_number;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int err_pulses = 0;
    logic [7:0] sb_q [$];
    int tx_cyc [$];
    logic [7:0] exp_m;

    typedef struct packed {
        logic       s0v;
        logic       s1v;
        logic       ir;
        logic       s0r;
        logic       s1r;
        logic       tx;
        logic       en;
        logic [2:0] cnt;
    } vec_t;
    vec_t tbl [10];

    interboard_tx_scheduler #(
        .FIFO_DEPTH     (Depth),
        .TIMEOUT_CYCLES (Tmo),
        .MAX_RETRY      (Retry)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .src0_valid     (src0_valid),
        .src0_msg_type  (src0_msg_type),
        .src0_number    (src0_number),
        .src0_ready     (src0_ready),
        .src1_valid     (src1_valid),
        .src1_msg_type  (src1_msg_type),
        .src1_number    (src1_number),
        .src1_ready     (src1_ready),
        .inter_ready    (inter_ready),
        .transmit       (transmit),
        .ctrl_en        (ctrl_en),
        .ctrl_msg_type  (ctrl_msg_type),
        .ctrl_number    (ctrl_number),
        .fifo_count     (fifo_count),
        .tx_error       (tx_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor at the falling edge: accepted messages feed the scoreboard, launches drain it.
    always @(negedge clk) begin
        if (rst) begin
            if (src0_valid && src0_ready) sb_q.push_back({src0_msg_type, src0_number});
            if (src1_valid && src1_ready) sb_q.push_back({src1_msg_type, src1_number});
            if (transmit) begin
                tx_cnt++;
                tx_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    chk("launch_unexpected", 32'(1), 32'(0));
                end else begin
                    exp_m = sb_q.pop_front();
                    chk("launch_data", 32'({ctrl_msg_type, ctrl_number}), 32'(exp_m));
                end
            end
            if (tx_error) err_pulses++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tx();
        int k = 0;
        while (!transmit && k < 30) begin
            step();
            k++;
        end
        chk("launch_seen", 32'(transmit), 32'(1));
    endtask

    // Called in the launch cycle: busy for three cycles, then idle again.
    task automatic handshake();
        step();
        inter_ready = 1'b0;
        step();
        step();
        step();
        inter_ready = 1'b1;
        step();
    endtask

    task automatic serve(input int n);
        for (int m = 0; m < n; m++) begin
            inter_ready = 1'b1;
            wait_tx();
            handshake();
        end
    endtask

    task automatic push0(input logic [2:0] t, input logic [4:0] n);
        src0_valid    = 1'b1;
        src0_msg_type = t;
        src0_number   = n;
        #1;
        chk("push0_ready", 32'(src0_ready), 32'(1));
        step();
        src0_valid = 1'b0;
    endtask

    initial begin
        int t0, e0, base, k;

        //          s0v   s1v   ir    s0r   s1r   tx    en    cnt
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};

        // Reset state, with requests pending.
        src0_valid = 1'b1;
        src1_valid = 1'b1;
        #12;
        chk("rst_s0_ready", 32'(src0_ready), 32'(0));
        chk("rst_s1_ready", 32'(src1_ready), 32'(0));
        chk("rst_count", 32'(fifo_count), 32'(0));
        chk("rst_ctrl_en", 32'(ctrl_en), 32'(0));
        chk("rst_transmit", 32'(transmit), 32'(0));
        chk("rst_tx_error", 32'(tx_error), 32'(0));
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        #10 rst = 1'b1;
        step();

        // Single message: launch latency and handshake.
        push0(3'd2, 5'd17);
        chk("single_c1_count", 32'(fifo_count), 32'(1));
        chk("single_c1_tx", 32'(transmit), 32'(0));
        step();
        chk("single_c2_tx", 32'(transmit), 32'(1));
        chk("single_c2_en", 32'(ctrl_en), 32'(1));
        chk("single_c2_type", 32'(ctrl_msg_type), 32'(2));
        chk("single_c2_num", 32'(ctrl_number), 32'(17));
        chk("single_c2_count", 32'(fifo_count), 32'(0));
        step();
        chk("single_c3_tx", 32'(transmit), 32'(0));
        inter_ready = 1'b0;
        step();
        step();
        step();
        chk("single_busy_en", 32'(ctrl_en), 32'(1));
        inter_ready = 1'b1;
        step();
        chk("single_done_en", 32'(ctrl_en), 32'(0));
        chk("single_tx_cnt", 32'(tx_cnt), 32'(1));

        // Arbitration, full and push-while-popping table.
        for (int i = 0; i < 10; i++) begin
            src0_valid    = tbl[i].s0v;
            src0_msg_type = 3'd0;
            src0_number   = 5'(i);
            src1_valid    = tbl[i].s1v;
            src1_msg_type = 3'd7;
            src1_number   = 5'(i + 16);
            inter_ready   = tbl[i].ir;
            #1;
            chk($sformatf("tbl%0d_s0_ready", i), 32'(src0_ready), 32'(tbl[i].s0r));
            chk($sformatf("tbl%0d_s1_ready", i), 32'(src1_ready), 32'(tbl[i].s1r));
            chk($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_transmit", i), 32'(transmit), 32'(tbl[i].tx));
            chk($sformatf("tbl%0d_ctrl_en", i), 32'(ctrl_en), 32'(tbl[i].en));
            step();
        end
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        serve(4);
        chk("drain_count", 32'(fifo_count), 32'(0));
        chk("drain_sb_empty", 32'(sb_q.size()), 32'(0));
        chk("drain_tx_cnt", 32'(tx_cnt), 32'(6));

        // Ordering: queue three while the link is busy, then serve them.
        inter_ready = 1'b0;
        push0(3'd1, 5'd5);
        push0(3'd4, 5'd9);
        push0(3'd6, 5'd30);
        chk("order_count", 32'(fifo_count), 32'(3));
        t0 = tx_cnt;
        serve(3);
        chk("order_tx_cnt", 32'(tx_cnt - t0), 32'(3));
        chk("order_sb_empty", 32'(sb_q.size()), 32'(0));
        chk("order_idle_en", 32'(ctrl_en), 32'(0));

        // Timeout: link never goes busy; three launches then a drop, next message follows.
        inter_ready = 1'b1;
        t0 = tx_cnt;
        e0 = err_pulses;
        base = tx_cyc.size();
        push0(3'd3, 5'd11);
        sb_q.push_back({3'd3, 5'd11});
        sb_q.push_back({3'd3, 5'd11});
        push0(3'd5, 5'd22);
        k = 0;
        while (!tx_error && k < 60) begin
            step();
            k++;
        end
        chk("tmo_error_seen", 32'(tx_error), 32'(1));
        chk("tmo_launches", 32'(tx_cyc.size() - base), 32'(3));
        if (tx_cyc.size() >= base + 3) begin
            chk("tmo_gap1", 32'(tx_cyc[base + 1] - tx_cyc[base]), 32'(9));
            chk("tmo_gap2", 32'(tx_cyc[base + 2] - tx_cyc[base + 1]), 32'(9));
            chk("tmo_err_gap", 32'(cyc - tx_cyc[base + 2]), 32'(9));
        end
        chk("tmo_err_en", 32'(ctrl_en), 32'(0));
        step();
        chk("tmo_next_tx", 32'(transmit), 32'(1));
        chk("tmo_err_width", 32'(tx_error), 32'(0));
        handshake();
        chk("tmo_err_pulses", 32'(err_pulses - e0), 32'(1));
        chk("tmo_tx_cnt", 32'(tx_cnt - t0), 32'(4));
        chk("tmo_sb_empty", 32'(sb_q.size()), 32'(0));

        // Flush while a transfer is in WAIT_DONE with three entries queued.
        inter_ready = 1'b1;
        push0(3'd4, 5'd4);
        push0(3'd4, 5'd5);
        chk("flush_launch", 32'(transmit), 32'(1));
        push0(3'd4, 5'd6);
        inter_ready = 1'b0;
        push0(3'd4, 5'd7);
        chk("flush_pre_count", 32'(fifo_count), 32'(3));
        chk("flush_pre_en", 32'(ctrl_en), 32'(1));
        src0_valid     = 1'b1;
        src0_number    = 5'd8;
        interboard_rst = 1'b1;
        #1;
        chk("flush_s0_ready", 32'(src0_ready), 32'(0));
        step();
        interboard_rst = 1'b0;
        src0_valid     = 1'b0;
        sb_q.delete();
        chk("flush_count", 32'(fifo_count), 32'(0));
        chk("flush_en", 32'(ctrl_en), 32'(0));
        inter_ready = 1'b1;
        t0 = tx_cnt;
        for (int j = 0; j < 12; j++) step();
        chk("flush_no_tx", 32'(tx_cnt - t0), 32'(0));

        // Async reset mid-WAIT_BUSY.
        push0(3'd2, 5'd9);
        push0(3'd1, 5'd3);
        chk("arst_launch", 32'(transmit), 32'(1));
        step();
        chk("arst_pre_count", 32'(fifo_count), 32'(1));
        chk("arst_pre_en", 32'(ctrl_en), 32'(1));
        src0_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_transmit", 32'(transmit), 32'(0));
        chk("arst_en", 32'(ctrl_en), 32'(0));
        chk("arst_type", 32'(ctrl_msg_type), 32'(0));
        chk("arst_num", 32'(ctrl_number), 32'(0));
        chk("arst_count", 32'(fifo_count), 32'(0));
        chk("arst_tx_error", 32'(tx_error), 32'(0));
        chk("arst_s0_ready", 32'(src0_ready), 32'(0));
        chk("arst_s1_ready", 32'(src1_ready), 32'(0));
        sb_q.delete();
        t0 = tx_cnt;
        e0 = err_pulses;
        src0_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        for (int j = 0; j < 12; j++) step();
        chk("arst_no_tx", 32'(tx_cnt - t0), 32'(0));
        chk("arst_no_err", 32'(err_pulses - e0), 32'(0));
        chk("arst_end_count", 32'(fifo_count), 32'(0));
        chk("final_sb_empty", 32'(sb_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
